// File: rtl/posit_decoder.sv
// posit_decoder: bit-serial unpacker for 32-bit posits (es=3).
// Walks bits 30..0 one per cycle through REGIME, EXP and MANT, then publishes
// sign, regime value k, exponent and left-aligned fraction with a one-cycle done.
//
// Interface handshake: start is a level request that is only looked at while
// the unit is idle; the posit is captured on the accepting edge. done pulses
// for one cycle and the result outputs stay valid until the following done.
module posit_decoder #(
    parameter int N         = 32,
    parameter int ES        = 3,
    parameter bit TWOS_COMP = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  posit_in,
    output logic          sign_out,
    output logic [5:0]    k_out,
    output logic [ES-1:0] exp_out,
    output logic [N-1:0]  mantissa_out,
    output logic          is_zero,
    output logic          is_nar,
    output logic          done
);
    localparam int IW = $clog2(N);
    localparam int EW = $clog2(ES);

    typedef enum logic [2:0] {
        S_IDLE, S_SIGN, S_REGIME, S_EXP, S_MANT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pos_q, pos_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          sign_q, sign_d;
    logic [5:0]    k_q, k_d;
    logic [ES-1:0] exp_q, exp_d;
    logic [N-1:0]  mant_q, mant_d;
    logic          zero_q, zero_d;
    logic          nar_q, nar_d;

    logic          sign_out_q, sign_out_d;
    logic [5:0]    k_out_q, k_out_d;
    logic [ES-1:0] exp_out_q, exp_out_d;
    logic [N-1:0]  mant_out_q, mant_out_d;
    logic          is_zero_q, is_zero_d;
    logic          is_nar_q, is_nar_d;
    logic          done_q, done_d;

    logic          cur_bit;
    logic          reg_term;
    logic [EW-1:0] e_pos;
    logic [IW-1:0] m_pos;

    // State and result registers; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            k_q        <= '0;
            exp_q      <= '0;
            mant_q     <= '0;
            zero_q     <= 1'b0;
            nar_q      <= 1'b0;
            sign_out_q <= 1'b0;
            k_out_q    <= '0;
            exp_out_q  <= '0;
            mant_out_q <= '0;
            is_zero_q  <= 1'b0;
            is_nar_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            k_q        <= k_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            zero_q     <= zero_d;
            nar_q      <= nar_d;
            sign_out_q <= sign_out_d;
            k_out_q    <= k_out_d;
            exp_out_q  <= exp_out_d;
            mant_out_q <= mant_out_d;
            is_zero_q  <= is_zero_d;
            is_nar_q   <= is_nar_d;
            done_q     <= done_d;
        end
    end

    // Next-state and field extraction; one posit bit consumed per scan cycle.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        k_d        = k_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        zero_d     = zero_q;
        nar_d      = nar_q;
        sign_out_d = sign_out_q;
        k_out_d    = k_out_q;
        exp_out_d  = exp_out_q;
        mant_out_d = mant_out_q;
        is_zero_d  = is_zero_q;
        is_nar_d   = is_nar_q;
        done_d     = 1'b0;
        cur_bit    = pos_q[idx_q];
        reg_term   = 1'b0;
        e_pos      = EW'(ES - 1) - cnt_q[EW-1:0];
        m_pos      = IW'(N - 1) - cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pos_d   = posit_in;
                    idx_d   = IW'(N - 2);
                    cnt_d   = '0;
                    sign_d  = 1'b0;
                    k_d     = '0;
                    exp_d   = '0;
                    mant_d  = '0;
                    zero_d  = 1'b0;
                    nar_d   = 1'b0;
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                sign_d = pos_q[N-1];
                if (pos_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else if (pos_q == {1'b1, {(N-1){1'b0}}}) begin
                    nar_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (TWOS_COMP && pos_q[N-1]) begin
                        pos_d = ~pos_q + N'(1);
                    end
                    state_d = S_REGIME;
                end
            end
            S_REGIME: begin
                // Run polarity is bit 30 of the scanned word, which is the first regime bit.
                if (idx_q == IW'(N - 2)) begin
                    k_d = cur_bit ? 6'd0 : 6'h3F;
                end else if (cur_bit == pos_q[N-2]) begin
                    k_d = pos_q[N-2] ? (k_q + 6'd1) : (k_q - 6'd1);
                end else begin
                    reg_term = 1'b1;
                end
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                    if (reg_term) begin
                        cnt_d   = '0;
                        state_d = S_EXP;
                    end
                end
            end
            S_EXP: begin
                exp_d[e_pos] = cur_bit;
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                    if (cnt_q == IW'(ES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_MANT;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            S_MANT: begin
                mant_d[m_pos] = cur_bit;
                cnt_d         = cnt_q + IW'(1);
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                sign_out_d = sign_q;
                k_out_d    = k_q;
                exp_out_d  = exp_q;
                mant_out_d = mant_q;
                is_zero_d  = zero_q;
                is_nar_d   = nar_q;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sign_out     = sign_out_q;
    assign k_out        = k_out_q;
    assign exp_out      = exp_out_q;
    assign mantissa_out = mant_out_q;
    assign is_zero      = is_zero_q;
    assign is_nar       = is_nar_q;
    assign done         = done_q;

endmodule
